// File: rtl/app_drain.sv
// app_drain: collects sorted result packets from the PE mesh into a small FIFO,
// checks that they arrive in address order with non-increasing data, and
// streams them downstream while reporting count, completion and error status.
module app_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int N          = 256,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 4000,
    localparam int WIDTH     = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH:0]        in_pkt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic [2:0]            err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0] N_CNT    = (ADDR_WIDTH + 1)'(N);
    localparam logic [CW-1:0]       TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [AW:0]         FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FLUSH,
        DONE
    } state_t;

    state_t state;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           level;
    logic [CW-1:0]         cycles;
    logic [DATA_WIDTH-1:0] prev_data;

    logic                  in_flag;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic last_pkt;
    logic timed_out;
    logic order_bad;
    logic sort_bad;

    assign {in_flag, in_addr, in_data} = in_pkt;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LVL);
    assign in_ready   = (state == COLLECT) && !fifo_full;
    assign out_valid  = !fifo_empty;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    // Head data is masked while empty so stale entries never leak out after reset.
    assign out_addr = fifo_empty ? '0 : mem[rd_ptr][WIDTH-1:DATA_WIDTH];
    assign out_data = fifo_empty ? '0 : mem[rd_ptr][DATA_WIDTH-1:0];

    // The k-th packet must carry addr k and data no larger than its predecessor.
    assign last_pkt  = push && (count == N_CNT - 1'b1);
    assign timed_out = (cycles == TO_LAST);
    assign order_bad = ({1'b0, in_addr} != count);
    assign sort_bad  = (count != '0) && (in_data > prev_data);

    // FIFO storage: written on every accepted packet, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_pkt[WIDTH-1:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (!push && pop) begin
                level <= level - 1'b1;
            end
        end
    end

    // Run control: arms on start, tracks count/errors/timeout, flushes, then reports done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            done      <= 1'b0;
            err       <= 3'b000;
            cycles    <= '0;
            prev_data <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= COLLECT;
                        count     <= '0;
                        done      <= 1'b0;
                        err       <= 3'b000;
                        cycles    <= '0;
                        prev_data <= '0;
                    end
                end
                COLLECT: begin
                    cycles <= cycles + 1'b1;
                    if (push) begin
                        if (count != N_CNT) begin
                            count <= count + 1'b1;
                        end
                        prev_data <= in_data;
                        if (in_flag) begin
                            err[0] <= 1'b1;
                        end
                        if (order_bad || sort_bad) begin
                            err[1] <= 1'b1;
                        end
                    end
                    if (last_pkt) begin
                        state <= FLUSH;
                    end else if (timed_out) begin
                        err[2] <= 1'b1;
                        state  <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fifo_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
